sram_seq_ctrl: RTL and testbench

//   Synchronous initiator for the 32K x 32-bit asynchronous SRAM array (four 8-bit 32K banks, active-low CS/OE/WE).

---
 rtl/sram_seq_ctrl.sv | 94 +++++++++
 tb/tb_sram_seq_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/sram_seq_ctrl.sv
// sram_seq_ctrl: turns a one-cycle request into a timed SETUP/ACCESS/HOLD strobe
// sequence for an asynchronous 32-bit SRAM array, returning read data and a one-cycle ack.
module sram_seq_ctrl #(
   parameter int ADDR_W     = 15,
   parameter int DATA_W     = 32,
   parameter int SETUP_CYC  = 1,
   parameter int ACCESS_CYC = 2,
   parameter int HOLD_CYC   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ack,
   output logic              busy,
   output logic              overrun,
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_d_write,
   input  logic [DATA_W-1:0] mem_d_read,
   output logic              mem_cs,
   output logic              mem_oe,
   output logic              mem_we
);
   localparam int MAX_SA  = (SETUP_CYC > ACCESS_CYC) ? SETUP_CYC : ACCESS_CYC;
   localparam int MAX_CYC = (MAX_SA > HOLD_CYC) ? MAX_SA : HOLD_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;
   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic              rw_q, rw_nx, done;
   logic [ADDR_W-1:0] a_nx;
   logic [DATA_W-1:0] d_nx, rdata_nx;
   assign done = cnt == '0;
   always_comb begin
      state_nx = state;
      cnt_nx   = done ? cnt : cnt - CNT_W'(1);
      rw_nx    = rw_q;
      a_nx     = mem_a;
      d_nx     = mem_d_write;
      rdata_nx = rdata;
      case (state)
         IDLE: if (req) begin
            state_nx = SETUP;
            cnt_nx   = CNT_W'(SETUP_CYC - 1);
            rw_nx    = rw;
            a_nx     = addr;
            d_nx     = wdata;
         end
         SETUP: if (done) begin
            state_nx = ACCESS;
            cnt_nx   = CNT_W'(ACCESS_CYC - 1);
         end
         ACCESS: if (done) begin
            state_nx = HOLD;
            cnt_nx   = CNT_W'(HOLD_CYC - 1);
            rdata_nx = rw_q ? rdata : mem_d_read;
         end
         default: if (done) state_nx = IDLE;
      endcase
   end
   // strobes are derived from the next state so they change on the same edge as the state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         rw_q        <= 1'b0;
         mem_a       <= '0;
         mem_d_write <= '0;
         rdata       <= '0;
         ack         <= 1'b0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
         mem_cs      <= 1'b1;
         mem_oe      <= 1'b1;
         mem_we      <= 1'b1;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         rw_q        <= rw_nx;
         mem_a       <= a_nx;
         mem_d_write <= d_nx;
         rdata       <= rdata_nx;
         ack         <= state == HOLD && state_nx == IDLE;
         busy        <= state_nx != IDLE;
         overrun     <= overrun | (req && state != IDLE);
         mem_cs      <= state_nx == IDLE;
         mem_oe      <= !(state_nx == ACCESS && !rw_nx);
         mem_we      <= !(state_nx == ACCESS && rw_nx);
      end
   end
endmodule

// File: tb/tb_sram_seq_ctrl.sv
// tb_sram_seq_ctrl: directed vectors, corner sequences and random traffic checked
// against a transaction-level model with an asynchronous SRAM array attached.
module tb_sram_seq_ctrl;
   localparam int S = 1, A = 2, H = 1, L = S + A + H;
   logic        clk = 1'b0, rst, req, rw;
   logic [14:0] addr, mem_a;
   logic [31:0] wdata, rdata, mem_d_write, mem_d_read;
   logic        ack, busy, overrun, mem_cs, mem_oe, mem_we;
   always #5 clk = ~clk;
   sram_seq_ctrl dut (
      .clk(clk), .rst(rst), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ack(ack), .busy(busy), .overrun(overrun),
      .mem_a(mem_a), .mem_d_write(mem_d_write), .mem_d_read(mem_d_read),
      .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we)
   );
   logic [31:0] sram [0:32767];
   assign mem_d_read = (!mem_cs && !mem_oe) ? sram[mem_a] : 32'h0;
   always @(negedge clk) if (!mem_cs && !mem_we) sram[mem_a] <= mem_d_write;
   int n_cmp = 0, n_err = 0;
   int left = 0;
   bit t_rw = 0, t_known = 0, rd_known = 1, exp_ovr = 0, exp_ack = 0;
   logic [14:0] t_a = '0;
   logic [31:0] t_d = '0, t_rd = '0, exp_rdata = '0;
   logic [31:0] ref_mem [int];
   int ncs, noe, nwe, nack;
   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endfunction
   task automatic check_all();
      bit acc;
      acc = left <= A + H && left > H;
      chk("busy", busy, 32'(left > 0));
      chk("cs", mem_cs, 32'(left == 0));
      chk("oe", mem_oe, 32'(!(acc && !t_rw)));
      chk("we", mem_we, 32'(!(acc && t_rw)));
      chk("ack", ack, 32'(exp_ack));
      chk("overrun", overrun, 32'(exp_ovr));
      chk("mem_a", mem_a, 32'(t_a));
      chk("mem_d_write", mem_d_write, t_d);
      if (left == 0 && rd_known) chk("rdata", rdata, exp_rdata);
   endtask
   task automatic tick(input bit r, input bit w, input logic [14:0] a, input logic [31:0] d);
      req = r; rw = w; addr = a; wdata = d;
      @(posedge clk);
      exp_ack = 0;
      if (left > 0) begin
         if (r) exp_ovr = 1;
         left--;
         if (left == 0) begin
            exp_ack = 1;
            if (!t_rw) begin exp_rdata = t_rd; rd_known = t_known; end
         end
      end else if (r) begin
         left = L; t_rw = w; t_a = a; t_d = d;
         if (w) ref_mem[int'(a)] = d;
         else begin
            t_known = ref_mem.exists(int'(a));
            t_rd = t_known ? ref_mem[int'(a)] : 32'h0;
         end
      end
      #1;
      check_all();
      ncs += int'(!mem_cs); noe += int'(!mem_oe); nwe += int'(!mem_we); nack += int'(ack);
   endtask
   task automatic model_reset();
      if (left > 0 && t_rw) ref_mem.delete(int'(t_a));
      left = 0; exp_ack = 0; exp_ovr = 0; t_a = '0; t_d = '0; exp_rdata = '0; rd_known = 1;
   endtask
   task automatic mid_cycle_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_cs", mem_cs, 1); chk("rst_we", mem_we, 1); chk("rst_oe", mem_oe, 1);
      chk("rst_ack", ack, 0); chk("rst_busy", busy, 0); chk("rst_rdata", rdata, 0);
      model_reset();
      @(posedge clk); #1 rst = 1'b0;
      check_all();
   endtask
   task automatic txn(input bit w, input logic [14:0] a, input logic [31:0] d);
      ncs = 0; noe = 0; nwe = 0; nack = 0;
      tick(1'b1, w, a, d);
      for (int k = 0; k < L; k++) tick(1'b0, 1'b0, '0, '0);
      chk("ack_latency", ack, 1);
      chk("cs_cycles", ncs, L);
      chk("oe_cycles", noe, w ? 0 : A);
      chk("we_cycles", nwe, w ? A : 0);
      chk("ack_count", nack, 1);
   endtask
   typedef struct { bit rw; logic [14:0] a; logic [31:0] d; logic [31:0] exp_rd; } vec_t;
   vec_t vecs [5];
   logic [14:0] pool [8];
   initial begin
      vecs[0] = '{1'b1, 15'h1234, 32'hDEADBEEF, 32'h0};
      vecs[1] = '{1'b0, 15'h1234, 32'h0, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 15'h0000, 32'h01234567, 32'h0};
      vecs[3] = '{1'b1, 15'h0020, 32'h20202020, 32'h0};
      vecs[4] = '{1'b0, 15'h0000, 32'h0, 32'h01234567};
      pool = '{15'h0000, 15'h7FFF, 15'h1234, 15'h0010, 15'h0020, 15'h0030, 15'h0001, 15'h7FFE};
      rst = 1'b1; req = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
      #12;
      check_all();
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 5; i++) begin
         txn(vecs[i].rw, vecs[i].a, vecs[i].d);
         if (vecs[i].rw) chk("array_word", sram[vecs[i].a], vecs[i].d);
         else chk("vec_rdata", rdata, vecs[i].exp_rd);
         tick(1'b0, 1'b0, '0, '0);
         if (!vecs[i].rw) chk("rdata_stable", rdata, vecs[i].exp_rd);
      end
      tick(1'b1, 1'b1, 15'h7FFF, 32'hA5A5A5A5);
      for (int k = 0; k < L; k++) tick(1'b0, 1'b0, '0, '0);
      chk("b2b_ack", ack, 1);
      chk("b2b_cs_gap", mem_cs, 1);
      tick(1'b1, 1'b0, 15'h0000, 32'h0);
      chk("b2b_accept", busy, 1);
      for (int k = 0; k < L; k++) tick(1'b0, 1'b0, '0, '0);
      chk("b2b_rdata", rdata, 32'h01234567);
      txn(1'b0, 15'h7FFF, '0);
      chk("top_word", rdata, 32'hA5A5A5A5);
      nack = 0;
      tick(1'b1, 1'b1, 15'h0010, 32'h10101010);
      tick(1'b0, 1'b0, '0, '0);
      tick(1'b1, 1'b0, 15'h0055, 32'hFFFFFFFF);
      for (int k = 0; k < 8; k++) tick(1'b0, 1'b0, '0, '0);
      chk("ovr_single_ack", nack, 1);
      chk("ovr_word", sram[15'h0010], 32'h10101010);
      chk("ovr_sticky", overrun, 1);
      tick(1'b1, 1'b1, 15'h0030, 32'h30303030);
      tick(1'b0, 1'b0, '0, '0);
      tick(1'b0, 1'b0, '0, '0);
      mid_cycle_reset();
      nack = 0;
      for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, '0, '0);
      chk("rst_no_ack", nack, 0);
      txn(1'b0, 15'h0020, '0);
      chk("post_rst_read", rdata, 32'h20202020);
      for (int i = 0; i < 3000; i++)
         tick($urandom_range(0, 2) == 0, 1'($urandom), pool[$urandom_range(0, 7)], $urandom);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
